// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM states, default geometry and the digit-count rule.
package bcd_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_CONVERT
    } bcd_state_t;

    localparam int unsigned DEFAULT_WIDTH  = 8;
    localparam int unsigned DEFAULT_DIGITS = 3;

    // Smallest digit count d with 10^d > 2^width - 1 (valid for width <= 60).
    function automatic int unsigned digits_needed(input int unsigned width);
        longint unsigned max_val;
        longint unsigned limit;
        int unsigned     d;
        max_val = (64'd1 << width) - 64'd1;
        limit   = 64'd10;
        d       = 1;
        while (limit <= max_val) begin
            d     = d + 1;
            limit = limit * 64'd10;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added
// (modulo 16) so the following left shift carries into the next digit.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 converter with start/busy/done handshake.
// The bcd output register only updates on the final shift, so it never shows scratch values.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned DIGITS = DEFAULT_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    if (DIGITS < digits_needed(WIDTH)) begin : g_bad_digits
        $fatal(1, "bin_to_bcd_seq: DIGITS too small for WIDTH");
    end

    bcd_state_t            state;
    logic [WIDTH-1:0]      bin_sr;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   shifted;
    logic [CW-1:0]         cnt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scratch[4*g +: 4]),
            .adjusted (adj[4*g +: 4])
        );
    end

    // Correct first, then shift the next binary MSB into the scratch LSB.
    always_comb begin
        shifted = {adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_sr  <= bin;
                        scratch <= '0;
                        cnt     <= CW'(WIDTH);
                        busy    <= 1'b1;
                        state   <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    scratch <= shifted;
                    bin_sr  <= bin_sr << 1;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd   <= shifted;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
